uart_tx_arbiter: RTL and testbench

Round-robin controller that shares one `uart_transmitter` among four byte-producing requesters. It takes a byte from the granted requester and issues exactly one `Tx_WR` pulse. It then tracks the transmitter's `Tx_BUSY` rise and fall before granting again. It sits between the user-side producers and the transmitter inside the UART top level, and owns the transmitter's `Tx_EN`, `Tx_WR` and `Tx_DATA` inputs.

---
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four byte producers.
// Each grant issues one Tx_WR, then waits for Tx_BUSY to rise and fall (or time out) before re-arbitrating.
module uart_tx_arbiter #(
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_enable,
   input  logic [3:0]  i_req,
   input  logic [31:0] i_req_data,
   output logic [3:0]  o_ack,
   output logic        o_tx_en,
   output logic        o_tx_wr,
   output logic [7:0]  o_tx_data,
   input  logic        i_tx_busy,
   output logic [1:0]  o_grant_id,
   output logic        o_active,
   output logic        o_err_timeout
);
   localparam int            CW       = $clog2(BUSY_TIMEOUT) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(BUSY_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, WRITE, WAIT_BUSY, WAIT_DONE} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [1:0]    r_ptr;
   logic [1:0]    w_sel;
   logic          w_sel_vld;
   logic          w_grant;
   logic          w_err_set;

   logic [3:0]    r_ack;
   logic          r_tx_wr;
   logic [7:0]    r_tx_data;
   logic          r_tx_en;
   logic [1:0]    r_grant_id;
   logic          r_active;
   logic          r_err_timeout;

   // Offsets are walked from 4 down to 1 so the nearest requester after the pointer wins.
   always_comb begin
      w_sel     = r_ptr;
      w_sel_vld = 1'b0;
      for (int k = 4; k >= 1; k--) begin
         if (i_req[r_ptr + 2'(k)]) begin
            w_sel     = r_ptr + 2'(k);
            w_sel_vld = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_grant     = 1'b0;
      w_err_set   = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_enable && w_sel_vld && !i_tx_busy) begin
               w_grant     = 1'b1;
               w_state_nxt = WRITE;
            end
         end
         WRITE: begin
            w_cnt_nxt   = '0;
            w_state_nxt = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            // A busy rise on the final counted cycle still counts as success.
            if (i_tx_busy) begin
               w_state_nxt = WAIT_DONE;
            end else if (r_cnt == LAST_CNT) begin
               w_err_set   = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         WAIT_DONE: begin
            if (!i_tx_busy) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_ack         <= 4'b0000;
         r_tx_wr       <= 1'b0;
         r_tx_data     <= 8'h00;
         r_tx_en       <= 1'b0;
         r_grant_id    <= 2'd0;
         r_ptr         <= 2'd3;
         r_active      <= 1'b0;
         r_err_timeout <= 1'b0;
      end else begin
         r_ack    <= w_grant ? (4'b0001 << w_sel) : 4'b0000;
         r_tx_wr  <= w_grant;
         r_tx_en  <= i_enable | (r_state != IDLE);
         r_active <= (w_state_nxt != IDLE);
         if (w_grant) begin
            r_tx_data  <= i_req_data[{w_sel, 3'b000} +: 8];
            r_grant_id <= w_sel;
            r_ptr      <= w_sel;
         end
         if (w_err_set) begin
            r_err_timeout <= 1'b1;
         end
      end
   end

   assign o_ack         = r_ack;
   assign o_tx_wr       = r_tx_wr;
   assign o_tx_data     = r_tx_data;
   assign o_tx_en       = r_tx_en;
   assign o_grant_id    = r_grant_id;
   assign o_active      = r_active;
   assign o_err_timeout = r_err_timeout;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a transfer-level reference model.
module tb_uart_tx_arbiter;
   localparam int T = 16;

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_enable;
   logic [3:0]  i_req;
   logic [31:0] i_req_data;
   logic        i_tx_busy;
   logic [3:0]  o_ack;
   logic        o_tx_en;
   logic        o_tx_wr;
   logic [7:0]  o_tx_data;
   logic [1:0]  o_grant_id;
   logic        o_active;
   logic        o_err_timeout;

   uart_tx_arbiter #(.BUSY_TIMEOUT(T)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_req(i_req),
      .i_req_data(i_req_data), .o_ack(o_ack), .o_tx_en(o_tx_en), .o_tx_wr(o_tx_wr),
      .o_tx_data(o_tx_data), .i_tx_busy(i_tx_busy), .o_grant_id(o_grant_id),
      .o_active(o_active), .o_err_timeout(o_err_timeout)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Transmitter model: busy rises busy_lat cycles after a Tx_WR cycle, for busy_len cycles.
   bit model_on  = 1'b0;
   bit ext_busy  = 1'b0;
   int busy_lat  = 1;
   int busy_len  = 3;
   int busy_left = 0;
   int pend      = 0;

   typedef struct {
      logic [3:0]  req;
      logic [31:0] data;
      logic [3:0]  exp_ack;
      logic [7:0]  exp_data;
   } vec_t;
   vec_t vt[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic tx_drive();
      if (busy_left > 0) busy_left--;
      if (pend > 0) begin
         pend--;
         if (pend == 0) busy_left = busy_len;
      end
      if (model_on && o_tx_wr && busy_lat > 0) pend = busy_lat;
      i_tx_busy = (busy_left > 0) || ext_busy;
   endtask

   task automatic cycle();
      tick();
      tx_drive();
   endtask

   task automatic do_reset();
      i_reset    = 1'b1;
      i_req      = 4'b0000;
      i_enable   = 1'b0;
      i_req_data = 32'h0;
      ext_busy   = 1'b0;
      busy_left  = 0;
      pend       = 0;
      i_tx_busy  = 1'b0;
      tick();
      tick();
      i_reset = 1'b0;
      tick();
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 60; n++) begin
         cycle();
         if (!o_active) break;
      end
      chk("wait_idle", o_active, 0);
   endtask

   function automatic int rr_pick(input int ptr, input logic [3:0] req);
      for (int off = 1; off <= 4; off++) begin
         if (req[(ptr + off) % 4]) return (ptr + off) % 4;
      end
      return 0;
   endfunction

   // Reference-model state for the random phase
   bit          m_idle;
   bit          m_rose;
   bit          m_err;
   bit          was_idle;
   int          m_ptr;
   int          m_w;
   int          m_gid;
   int          sel;
   logic [7:0]  m_data;
   logic [3:0]  exp_ack;
   logic [3:0]  p_req;
   logic [31:0] p_data;
   bit          p_en;
   bit          p_busy;
   logic [3:0]  rq;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wr_cnt;
      int low_at;

      vt[0] = '{4'b0001, 32'h000000A5, 4'b0001, 8'hA5};
      vt[1] = '{4'b1111, 32'h13121110, 4'b0010, 8'h11};
      vt[2] = '{4'b1111, 32'h13121110, 4'b0100, 8'h12};
      vt[3] = '{4'b1111, 32'h13121110, 4'b1000, 8'h13};
      vt[4] = '{4'b1111, 32'h13121110, 4'b0001, 8'h10};
      vt[5] = '{4'b0100, 32'h13121110, 4'b0100, 8'h12};
      vt[6] = '{4'b0101, 32'h13121110, 4'b0001, 8'h10};
      vt[7] = '{4'b0101, 32'h13121110, 4'b0100, 8'h12};
      vt[8] = '{4'b1010, 32'h13121110, 4'b1000, 8'h13};
      vt[9] = '{4'b1010, 32'h13121110, 4'b0010, 8'h11};

      // Reset values, sampled while reset is held
      i_reset = 1'b1; i_enable = 1'b1; i_req = 4'b1111; i_req_data = 32'hFFFFFFFF; i_tx_busy = 1'b0;
      tick();
      tick();
      chk("rst_ack", o_ack, 0);
      chk("rst_tx_wr", o_tx_wr, 0);
      chk("rst_tx_data", o_tx_data, 0);
      chk("rst_tx_en", o_tx_en, 0);
      chk("rst_grant_id", o_grant_id, 0);
      chk("rst_active", o_active, 0);
      chk("rst_err", o_err_timeout, 0);

      // Single transfer with a 20-cycle busy window
      do_reset();
      model_on = 1'b1; busy_lat = 1; busy_len = 20;
      i_enable = 1'b1; i_req = 4'b0001; i_req_data = 32'h000000A5;
      cycle();
      chk("single_ack", o_ack, 4'b0001);
      chk("single_wr", o_tx_wr, 1);
      chk("single_data", o_tx_data, 8'hA5);
      i_req = 4'b0000;
      wr_cnt = 0;
      low_at = -1;
      for (int k = 1; k <= 30; k++) begin
         cycle();
         if (k == 1) begin
            chk("single_ack_width", o_ack, 0);
            chk("single_wr_width", o_tx_wr, 0);
         end
         if (o_tx_wr) wr_cnt++;
         if (!o_active && low_at < 0) low_at = k;
      end
      chk("single_extra_wr", wr_cnt, 0);
      chk("single_active_low_cycle", low_at, busy_len + 2);
      chk("single_data_hold", o_tx_data, 8'hA5);

      // Vector table: round-robin order and pointer fairness
      do_reset();
      model_on = 1'b1; busy_lat = 1; busy_len = 3; i_enable = 1'b1;
      for (int r = 0; r < 10; r++) begin
         i_req = vt[r].req;
         i_req_data = vt[r].data;
         cycle();
         chk("vec_ack", o_ack, vt[r].exp_ack);
         chk("vec_wr", o_tx_wr, 1);
         chk("vec_data", o_tx_data, vt[r].exp_data);
         chk("vec_gid", o_grant_id, rr_pick((r == 0) ? 3 : 0, 4'b0000) == 0 ? $clog2(vt[r].exp_ack) : 0);
         i_req = 4'b0000;
         wait_idle();
      end

      // Timeout with busy never rising, then recovery
      do_reset();
      model_on = 1'b0; i_enable = 1'b1; i_req = 4'b0001; i_req_data = 32'h00000077;
      cycle();
      chk("to_wr", o_tx_wr, 1);
      i_req = 4'b0000;
      for (int k = 1; k <= T + 1; k++) begin
         cycle();
         if (k == T) begin
            chk("to_err_early", o_err_timeout, 0);
            chk("to_active_early", o_active, 1);
         end
         if (k == T + 1) begin
            chk("to_err", o_err_timeout, 1);
            chk("to_active", o_active, 0);
         end
      end
      model_on = 1'b1; busy_lat = 1; busy_len = 3;
      i_req = 4'b0010; i_req_data = 32'h00005500;
      cycle();
      chk("to_regrant_ack", o_ack, 4'b0010);
      chk("to_regrant_data", o_tx_data, 8'h55);
      i_req = 4'b0000;
      wait_idle();
      chk("to_err_sticky", o_err_timeout, 1);

      // Reset while in WRITE
      do_reset();
      model_on = 1'b1; busy_lat = 1; busy_len = 3; i_enable = 1'b1;
      i_req = 4'b0100; i_req_data = 32'h44332211;
      cycle();
      chk("rm_first_ack", o_ack, 4'b0100);
      i_req = 4'b0000;
      wait_idle();
      i_req = 4'b1111;
      cycle();
      chk("rm_second_ack", o_ack, 4'b1000);
      i_reset = 1'b1;
      #1;
      chk("rm_wr", o_tx_wr, 0);
      chk("rm_ack", o_ack, 0);
      chk("rm_tx_en", o_tx_en, 0);
      chk("rm_active", o_active, 0);
      busy_left = 0; pend = 0; i_tx_busy = 1'b0;
      tick();
      i_reset = 1'b0;
      cycle();
      chk("rm_after_ack", o_ack, 4'b0001);

      // Enable dropped during WAIT_DONE
      do_reset();
      model_on = 1'b1; busy_lat = 1; busy_len = 5; i_enable = 1'b1;
      i_req = 4'b1111; i_req_data = 32'hDDCCBBAA;
      cycle();
      chk("en_ack", o_ack, 4'b0001);
      for (int k = 1; k <= 20; k++) begin
         cycle();
         chk("en_no_ack", o_ack, 0);
         chk("en_tx_en", o_tx_en, (k <= 7) ? 1 : 0);
         chk("en_active", o_active, (k < 7) ? 1 : 0);
         if (k == 2) i_enable = 1'b0;
      end

      // Randomized traffic against the transfer-level model
      do_reset();
      model_on = 1'b1;
      m_idle = 1'b1; m_rose = 1'b0; m_err = 1'b0; m_ptr = 3; m_w = 0; m_gid = 0; m_data = 8'h00;
      rq = 4'b0000;
      for (int it = 0; it < 3000; it++) begin
         p_req = i_req; p_data = i_req_data; p_en = i_enable; p_busy = i_tx_busy;
         tick();
         was_idle = m_idle;
         exp_ack = 4'b0000;
         if (was_idle) begin
            if (p_en && p_req != 4'b0000 && !p_busy) begin
               sel = rr_pick(m_ptr, p_req);
               m_ptr = sel; m_gid = sel;
               exp_ack = 4'(1 << sel);
               m_data = p_data[8*sel +: 8];
               m_idle = 1'b0; m_w = cyc; m_rose = 1'b0;
            end
         end else if (cyc > m_w + 1) begin
            if (!m_rose) begin
               if (p_busy) m_rose = 1'b1;
               else if (cyc - 1 == m_w + T) begin
                  m_idle = 1'b1;
                  m_err  = 1'b1;
               end
            end else if (!p_busy) begin
               m_idle = 1'b1;
            end
         end
         chk("rnd_ack", o_ack, exp_ack);
         chk("rnd_wr", o_tx_wr, (exp_ack != 4'b0000) ? 1 : 0);
         chk("rnd_data", o_tx_data, m_data);
         chk("rnd_gid", o_grant_id, m_gid);
         chk("rnd_active", o_active, m_idle ? 0 : 1);
         chk("rnd_tx_en", o_tx_en, (p_en || !was_idle) ? 1 : 0);
         chk("rnd_err", o_err_timeout, m_err);

         for (int i = 0; i < 4; i++) begin
            if (o_ack[i]) rq[i] = 1'b0;
            else if (rq[i] && $urandom_range(0, 30) == 0) rq[i] = 1'b0;
            else if (!rq[i] && $urandom_range(0, 3) == 0) begin
               rq[i] = 1'b1;
               i_req_data[8*i +: 8] = 8'($urandom);
            end
         end
         i_req    = rq;
         i_enable = ($urandom_range(0, 9) != 0);
         ext_busy = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 7))
            0:       busy_lat = 0;
            1:       busy_lat = T;
            2:       busy_lat = T + 1;
            default: busy_lat = $urandom_range(1, 3);
         endcase
         busy_len = $urandom_range(1, 6);
         tx_drive();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
